// File: rtl/imem_boot_loader.sv
// Boot loader: parses a count header, payload words and an XOR checksum from a
// byte stream, writes the words into instruction memory and releases the core.
module imem_boot_loader #(
  parameter int N     = 32,
  parameter int DEPTH = 256,
  parameter int AW    = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  input  logic [7:0]    in_data,
  output logic          in_ready,
  output logic          imem_we,
  output logic [AW-1:0] imem_addr,
  output logic [N-1:0]  imem_wdata,
  output logic          core_run,
  output logic          load_err
);

  localparam int BPW = N / 8;
  localparam int BCW = (BPW > 1) ? $clog2(BPW) : 1;
  localparam logic [16:0] DEPTH_W = 17'(DEPTH);

  typedef enum logic [2:0] {
    HDR0 = 3'd0,
    HDR1 = 3'd1,
    LOAD = 3'd2,
    CSUM = 3'd3,
    RUN  = 3'd4,
    ERR  = 3'd5
  } state_t;

  state_t          state_reg, state_next;
  logic [15:0]     count_reg;
  logic [15:0]     word_idx_reg;
  logic [BCW-1:0]  byte_cnt_reg;
  logic [7:0]      csum_reg;
  logic [N-1:0]    word_reg;
  logic [N-1:0]    word_next;
  logic            imem_we_reg;
  logic [AW-1:0]   imem_addr_reg;
  logic [N-1:0]    imem_wdata_reg;

  logic        accept;
  logic        word_done;
  logic        last_word;
  logic [15:0] count_full;

  assign accept     = in_valid && in_ready;
  assign word_done  = (byte_cnt_reg == BCW'(BPW - 1));
  assign last_word  = (word_idx_reg == count_reg - 16'd1);
  assign count_full = {in_data, count_reg[7:0]};

  // Byte-lane steering: the incoming byte lands in the lane picked by byte_cnt.
  generate
    for (genvar gi = 0; gi < BPW; gi++) begin : g_lane
      assign word_next[gi*8 +: 8] = (byte_cnt_reg == BCW'(gi)) ? in_data
                                                                : word_reg[gi*8 +: 8];
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= HDR0;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    if (accept) begin
      case (state_reg)
        HDR0: state_next = HDR1;
        HDR1: begin
          if ({1'b0, count_full} > DEPTH_W) state_next = ERR;
          else if (count_full == 16'd0)     state_next = CSUM;
          else                              state_next = LOAD;
        end
        LOAD: if (word_done && last_word) state_next = CSUM;
        CSUM: state_next = (in_data == csum_reg) ? RUN : ERR;
        default: state_next = state_reg;
      endcase
    end
  end

  always_comb begin
    in_ready = (state_reg == HDR0) || (state_reg == HDR1) ||
               (state_reg == LOAD) || (state_reg == CSUM);
    core_run = (state_reg == RUN);
    load_err = (state_reg == ERR);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg      <= '0;
      word_idx_reg   <= '0;
      byte_cnt_reg   <= '0;
      csum_reg       <= '0;
      word_reg       <= '0;
      imem_we_reg    <= 1'b0;
      imem_addr_reg  <= '0;
      imem_wdata_reg <= '0;
    end else begin
      imem_we_reg <= 1'b0;
      if (accept) begin
        case (state_reg)
          HDR0: count_reg[7:0]  <= in_data;
          HDR1: count_reg[15:8] <= in_data;
          LOAD: begin
            csum_reg <= csum_reg ^ in_data;
            word_reg <= word_next;
            if (word_done) begin
              imem_we_reg    <= 1'b1;
              imem_addr_reg  <= word_idx_reg[AW-1:0];
              imem_wdata_reg <= word_next;
              word_idx_reg   <= word_idx_reg + 16'd1;
              byte_cnt_reg   <= '0;
            end else begin
              byte_cnt_reg <= byte_cnt_reg + BCW'(1);
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign imem_we    = imem_we_reg;
  assign imem_addr  = imem_addr_reg;
  assign imem_wdata = imem_wdata_reg;

endmodule

// File: tb/tb_imem_boot_loader.sv
// Directed bench for imem_boot_loader: fixed byte streams with hand-computed
// write addresses, words and final status.
module tb_imem_boot_loader;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        imem_we;
  logic [7:0]  imem_addr;
  logic [31:0] imem_wdata;
  logic        core_run;
  logic        load_err;

  int n_checks;
  int n_fail;
  int wr_count;
  int wr_base;
  logic [7:0]  log_addr [32];
  logic [31:0] log_data [32];

  imem_boot_loader #(.N(32), .DEPTH(256), .AW(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .core_run   (core_run),
    .load_err   (load_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Records every write strobe, sampled mid-cycle.
  initial wr_count = 0;
  always @(negedge clk) begin
    if (imem_we === 1'b1) begin
      log_addr[wr_count % 32] = imem_addr;
      log_data[wr_count % 32] = imem_wdata;
      wr_count = wr_count + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Offers one byte, returns 1 ns after the edge that accepts it.
  task automatic send(input logic [7:0] b);
    in_valid = 1'b1;
    in_data  = b;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic idle(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #2;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(1);
  endtask

  task automatic send_t1(input logic [7:0] csum);
    send(8'h02); send(8'h00);
    send(8'h78); send(8'h56); send(8'h34); send(8'h12);
    send(8'hEF); send(8'hBE); send(8'hAD); send(8'hDE);
    send(csum);
  endtask

  logic [7:0] t5_bytes [11];
  int         t5_gaps  [11];

  initial begin
    n_checks = 0;
    n_fail   = 0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    rst_n    = 1'b0;
    t5_bytes = '{8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h2A};
    t5_gaps  = '{0, 3, 1, 0, 2, 5, 0, 1, 4, 0, 2};
    #23;
    check("rst_in_ready", in_ready, 1);
    check("rst_we", imem_we, 0);
    check("rst_addr", imem_addr, 0);
    check("rst_wdata", imem_wdata, 0);
    check("rst_core_run", core_run, 0);
    check("rst_load_err", load_err, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle(1);

    // Test 1: two-word load, good checksum
    wr_base = wr_count;
    send(8'h02); send(8'h00);
    send(8'h78); send(8'h56); send(8'h34);
    check("t1_no_early_we", imem_we, 0);
    send(8'h12);
    check("t1_we0", imem_we, 1);
    check("t1_addr0", imem_addr, 0);
    check("t1_data0", imem_wdata, 32'h12345678);
    send(8'hEF);
    check("t1_we_pulse", imem_we, 0);
    send(8'hBE); send(8'hAD); send(8'hDE);
    check("t1_we1", imem_we, 1);
    check("t1_addr1", imem_addr, 1);
    check("t1_data1", imem_wdata, 32'hDEADBEEF);
    check("t1_ready_csum", in_ready, 1);
    check("t1_run_before", core_run, 0);
    send(8'h2A);
    check("t1_core_run", core_run, 1);
    check("t1_in_ready", in_ready, 0);
    check("t1_load_err", load_err, 0);
    idle(1);
    check("t1_writes", wr_count - wr_base, 2);

    // Test 2: empty load
    do_reset();
    wr_base = wr_count;
    send(8'h00); send(8'h00);
    check("t2_run_before", core_run, 0);
    check("t2_ready_csum", in_ready, 1);
    send(8'h00);
    check("t2_core_run", core_run, 1);
    check("t2_in_ready", in_ready, 0);
    idle(1);
    check("t2_writes", wr_count - wr_base, 0);

    // Test 3: bad checksum
    do_reset();
    wr_base = wr_count;
    send_t1(8'h2B);
    check("t3_load_err", load_err, 1);
    check("t3_core_run", core_run, 0);
    check("t3_in_ready", in_ready, 0);
    in_valid = 1'b1; in_data = 8'h55;
    idle(4);
    in_valid = 1'b0;
    check("t3_writes", wr_count - wr_base, 2);
    check("t3_err_sticky", load_err, 1);
    check("t3_run_still0", core_run, 0);

    // Test 4: count exceeds depth
    do_reset();
    wr_base = wr_count;
    send(8'h01);
    check("t4_err_before", load_err, 0);
    send(8'h01);
    check("t4_load_err", load_err, 1);
    check("t4_in_ready", in_ready, 0);
    check("t4_core_run", core_run, 0);
    idle(2);
    check("t4_writes", wr_count - wr_base, 0);

    // Test 5: stream with idle gaps, then extra bytes in RUN
    do_reset();
    wr_base = wr_count;
    for (int i = 0; i < 11; i++) begin
      idle(t5_gaps[i]);
      send(t5_bytes[i]);
    end
    check("t5_core_run", core_run, 1);
    check("t5_in_ready", in_ready, 0);
    in_valid = 1'b1; in_data = 8'h99;
    idle(5);
    in_valid = 1'b0;
    idle(1);
    check("t5_writes", wr_count - wr_base, 2);
    check("t5_addr0", log_addr[wr_base % 32], 0);
    check("t5_data0", log_data[wr_base % 32], 32'h12345678);
    check("t5_addr1", log_addr[(wr_base + 1) % 32], 1);
    check("t5_data1", log_data[(wr_base + 1) % 32], 32'hDEADBEEF);
    check("t5_run_sticky", core_run, 1);
    check("t5_err", load_err, 0);

    // Test 6: asynchronous abort mid-load, then full replay
    do_reset();
    send(8'h02); send(8'h00);
    send(8'h78); send(8'h56); send(8'h34); send(8'h12); send(8'hEF);
    check("t6_wdata_pre", imem_wdata, 32'h12345678);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_in_ready", in_ready, 1);
    check("t6_we", imem_we, 0);
    check("t6_addr", imem_addr, 0);
    check("t6_wdata", imem_wdata, 0);
    check("t6_core_run", core_run, 0);
    check("t6_load_err", load_err, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle(1);
    wr_base = wr_count;
    send_t1(8'h2A);
    check("t6_core_run_end", core_run, 1);
    check("t6_writes", wr_count - wr_base, 2);
    check("t6_first_addr", log_addr[wr_base % 32], 0);
    check("t6_first_data", log_data[wr_base % 32], 32'h12345678);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Hard time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
